// File: rtl/arb_pkg.sv
// Shared arbitration types and the default requester count used by the RS and FU blocks.
package arb_pkg;

    localparam int ARB_N_REQ = 16;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/pe.sv
// Lowest-set-bit priority encoder: one-hot winner, encoded index and found flag.
module pe #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     bits,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Isolate the lowest set bit, then OR-encode its position.
    always_comb begin
        onehot = bits & (~bits + {{(N-1){1'b0}}, 1'b1});
        idx    = {IDX_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx = idx | (onehot[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
        found = |bits;
    end

endmodule

// File: rtl/rr_mask_pe.sv
// Round-robin winner search: pointer-masked encoder with a wrap-around fallback.
module rr_mask_pe
    import arb_pkg::*;
#(
    parameter int N_REQ = ARB_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner_onehot,
    output logic [IDX_W-1:0] winner_idx,
    output logic             found
);

    logic [N_REQ-1:0] masked_s;
    logic [N_REQ-1:0] m_oh_s;
    logic [N_REQ-1:0] u_oh_s;
    logic [IDX_W-1:0] m_idx_s;
    logic [IDX_W-1:0] u_idx_s;
    logic             m_found_s;
    logic             u_found_s;

    assign masked_s = req & ({N_REQ{1'b1}} << ptr);

    pe #(.N(N_REQ), .IDX_W(IDX_W)) u_pe_masked (
        .bits   (masked_s),
        .onehot (m_oh_s),
        .idx    (m_idx_s),
        .found  (m_found_s)
    );

    pe #(.N(N_REQ), .IDX_W(IDX_W)) u_pe_all (
        .bits   (req),
        .onehot (u_oh_s),
        .idx    (u_idx_s),
        .found  (u_found_s)
    );

    // Nothing at or above the pointer means the search wraps to the lowest request.
    always_comb begin
        if (m_found_s) begin
            winner_onehot = m_oh_s;
            winner_idx    = m_idx_s;
        end else begin
            winner_onehot = u_oh_s;
            winner_idx    = u_idx_s;
        end
        found = u_found_s;
    end

endmodule

// File: rtl/rr_issue_arbiter.sv
// Round-robin issue arbiter sharing one FU port among RS entries; grant held until valid/ready.
// Build option RR_ARB_FIXED_PRIO_EN: pointer pinned at 0, giving pure lowest-index priority.
module rr_issue_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ = ARB_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [N_REQ-1:0] req,
    input  logic             fu_ready,
    output logic             grant_valid,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic [IDX_W-1:0] rr_ptr
);

    arb_state_t       state_r;
    logic [N_REQ-1:0] grant_oh_r;
    logic [IDX_W-1:0] grant_idx_r;
    logic [IDX_W-1:0] ptr_r;

    logic             handshake_s;
    logic [N_REQ-1:0] arb_req_s;
    logic [IDX_W-1:0] ptr_next_s;
    logic [N_REQ-1:0] win_oh_s;
    logic [IDX_W-1:0] win_idx_s;
    logic             win_found_s;

    // A completed handshake retires the current winner and moves the pointer just past it.
    always_comb begin
        handshake_s = (state_r == ARB_GRANT) && fu_ready;
        if (state_r == ARB_GRANT) begin
            arb_req_s = req & ~grant_oh_r;
        end else begin
            arb_req_s = req;
        end
`ifdef RR_ARB_FIXED_PRIO_EN
        ptr_next_s = {IDX_W{1'b0}};
`else
        if (handshake_s) begin
            ptr_next_s = grant_idx_r + IDX_W'(1);
        end else begin
            ptr_next_s = ptr_r;
        end
`endif
    end

    rr_mask_pe #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_mask_pe (
        .req           (arb_req_s),
        .ptr           (ptr_next_s),
        .winner_onehot (win_oh_s),
        .winner_idx    (win_idx_s),
        .found         (win_found_s)
    );

    // Grant FSM; flush wins over a coincident handshake and leaves the pointer alone.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ARB_IDLE;
            grant_oh_r  <= {N_REQ{1'b0}};
            grant_idx_r <= {IDX_W{1'b0}};
            ptr_r       <= {IDX_W{1'b0}};
        end else if (flush) begin
            state_r     <= ARB_IDLE;
            grant_oh_r  <= {N_REQ{1'b0}};
            grant_idx_r <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (win_found_s) begin
                        state_r     <= ARB_GRANT;
                        grant_oh_r  <= win_oh_s;
                        grant_idx_r <= win_idx_s;
                    end
                end
                ARB_GRANT: begin
                    if (handshake_s) begin
                        ptr_r <= ptr_next_s;
                        if (win_found_s) begin
                            grant_oh_r  <= win_oh_s;
                            grant_idx_r <= win_idx_s;
                        end else begin
                            state_r     <= ARB_IDLE;
                            grant_oh_r  <= {N_REQ{1'b0}};
                            grant_idx_r <= {IDX_W{1'b0}};
                        end
                    end
                end
                default: begin
                    state_r     <= ARB_IDLE;
                    grant_oh_r  <= {N_REQ{1'b0}};
                    grant_idx_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign grant_valid  = (state_r == ARB_GRANT);
    assign grant_onehot = grant_oh_r;
    assign grant_idx    = grant_idx_r;
    assign rr_ptr       = ptr_r;

endmodule

// File: tb/tb_rr_issue_arbiter.sv
// Self-checking bench for rr_issue_arbiter: directed vector table, reset corners, random vs reference model.
module tb_rr_issue_arbiter;

    localparam int N = 16;
    localparam int W = 4;
`ifdef RR_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic         clock;
    logic         reset_n;
    logic         flush;
    logic [N-1:0] req;
    logic         fu_ready;
    logic         grant_valid;
    logic [N-1:0] grant_onehot;
    logic [W-1:0] grant_idx;
    logic [W-1:0] rr_ptr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: grant presented, winner index, round-robin start.
    bit m_valid;
    int m_idx;
    int m_ptr;

    typedef struct {
        logic [15:0] req;
        logic        fu_ready;
        logic        flush;
        logic        exp_valid;
        int          exp_idx;
        int          exp_ptr;
    } vec_t;

    vec_t vecs[$];

    rr_issue_arbiter #(.N_REQ(N), .IDX_W(W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .req          (req),
        .fu_ready     (fu_ready),
        .grant_valid  (grant_valid),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .rr_ptr       (rr_ptr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // First requester found walking circularly upward from the start index.
    function automatic int find_from(input logic [15:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
    endfunction

    function automatic void model_edge(input logic [15:0] r, input logic fr, input logic fl);
        logic [15:0] rem;
        logic [15:0] one;
        one = 16'h0001;
        if (fl) begin
            m_valid = 1'b0;
            m_idx   = 0;
        end else if (!m_valid) begin
            if (r != 16'h0000) begin
                m_valid = 1'b1;
                m_idx   = find_from(r, m_ptr);
            end
        end else if (fr) begin
            if (!FIXED) m_ptr = (m_idx + 1) % N;
            rem = r & ~(one << m_idx);
            if (rem != 16'h0000) begin
                m_idx = find_from(rem, m_ptr);
            end else begin
                m_valid = 1'b0;
                m_idx   = 0;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input bit v, input int idx, input int ptr);
        logic [15:0] one;
        logic [15:0] oh;
        one = 16'h0001;
        oh  = v ? (one << idx) : 16'h0000;
        check({tag, ".grant_valid"},  {31'd0, grant_valid}, {31'd0, v});
        check({tag, ".grant_onehot"}, {16'd0, grant_onehot}, {16'd0, oh});
        check({tag, ".grant_idx"},    {28'd0, grant_idx}, 32'(v ? idx : 0));
        check({tag, ".rr_ptr"},       {28'd0, rr_ptr}, 32'(ptr));
    endtask

    // Drive one cycle's inputs at a falling edge, advance the model, sample at the next falling edge.
    task automatic step(input logic [15:0] r, input logic fr, input logic fl);
        req      = r;
        fu_ready = fr;
        flush    = fl;
        model_edge(r, fr, fl);
        @(negedge clock);
    endtask

    function automatic vec_t mk(input logic [15:0] r, input logic fr, input logic fl,
                                input logic v, input int idx, input int ptr);
        vec_t t;
        t.req = r; t.fu_ready = fr; t.flush = fl;
        t.exp_valid = v; t.exp_idx = idx; t.exp_ptr = ptr;
        return t;
    endfunction

    initial begin
        logic [15:0] rr;
        model_reset();

        // Reset held with every entry requesting.
        reset_n  = 1'b0;
        req      = 16'hFFFF;
        fu_ready = 1'b0;
        flush    = 1'b0;
        repeat (2) @(negedge clock);
        check_outputs("reset_hold", 1'b0, 0, 0);
        reset_n = 1'b1;
        #1;
        check_outputs("reset_release", 1'b0, 0, 0);
        @(negedge clock);
        #0;
        model_reset();
        req = 16'hFFFF;
        @(posedge clock);
        @(negedge clock);
        model_edge(16'hFFFF, 1'b0, 1'b0);
        check_outputs("first_grant", 1'b1, 0, 0);
        step(16'hFFFF, 1'b0, 1'b1);
        check_outputs("flush_to_idle", 1'b0, 0, 0);

`ifndef RR_ARB_FIXED_PRIO_EN
        // Sequential drain 8..11, wrap at 15, stall with changing req, flush over handshake.
        vecs.push_back(mk(16'h0F00, 1'b1, 1'b0, 1'b1,  8,  0));
        vecs.push_back(mk(16'h0F00, 1'b1, 1'b0, 1'b1,  9,  9));
        vecs.push_back(mk(16'h0E00, 1'b1, 1'b0, 1'b1, 10, 10));
        vecs.push_back(mk(16'h0C00, 1'b1, 1'b0, 1'b1, 11, 11));
        vecs.push_back(mk(16'h0800, 1'b1, 1'b0, 1'b0,  0, 12));
        vecs.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0,  0, 12));
        vecs.push_back(mk(16'h8000, 1'b0, 1'b0, 1'b1, 15, 12));
        vecs.push_back(mk(16'h8000, 1'b1, 1'b0, 1'b0,  0,  0));
        vecs.push_back(mk(16'h8001, 1'b0, 1'b0, 1'b1,  0,  0));
        vecs.push_back(mk(16'h8001, 1'b1, 1'b0, 1'b1, 15,  1));
        vecs.push_back(mk(16'h8000, 1'b1, 1'b0, 1'b0,  0,  0));
        vecs.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0,  0,  0));
        vecs.push_back(mk(16'h0008, 1'b0, 1'b0, 1'b1,  3,  0));
        vecs.push_back(mk(16'h0008, 1'b0, 1'b0, 1'b1,  3,  0));
        vecs.push_back(mk(16'h00F8, 1'b0, 1'b0, 1'b1,  3,  0));
        vecs.push_back(mk(16'h00F8, 1'b0, 1'b0, 1'b1,  3,  0));
        vecs.push_back(mk(16'h00F8, 1'b1, 1'b0, 1'b1,  4,  4));
        vecs.push_back(mk(16'h00F0, 1'b0, 1'b0, 1'b1,  4,  4));
        vecs.push_back(mk(16'h00F0, 1'b1, 1'b0, 1'b1,  5,  5));
        vecs.push_back(mk(16'h00E0, 1'b1, 1'b1, 1'b0,  0,  5));
        vecs.push_back(mk(16'h00E0, 1'b0, 1'b0, 1'b1,  5,  5));
        vecs.push_back(mk(16'h00E0, 1'b1, 1'b0, 1'b1,  6,  6));
        vecs.push_back(mk(16'h00C0, 1'b0, 1'b1, 1'b0,  0,  6));
        vecs.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0,  0,  6));
`else
        // Fixed priority: lowest index wins and the pointer never leaves 0.
        vecs.push_back(mk(16'h0101, 1'b0, 1'b0, 1'b1, 0, 0));
        vecs.push_back(mk(16'h0101, 1'b0, 1'b1, 1'b0, 0, 0));
        vecs.push_back(mk(16'h0101, 1'b0, 1'b0, 1'b1, 0, 0));
        vecs.push_back(mk(16'h0101, 1'b0, 1'b0, 1'b1, 0, 0));
        vecs.push_back(mk(16'h0101, 1'b1, 1'b1, 1'b0, 0, 0));
        vecs.push_back(mk(16'h0101, 1'b1, 1'b0, 1'b1, 0, 0));
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].req, vecs[i].fu_ready, vecs[i].flush);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_idx, vecs[i].exp_ptr);
            check_outputs($sformatf("vec%0d_model", i), m_valid, m_idx, m_ptr);
        end

        // Async reset while a grant is presented: outputs clear without waiting for an edge.
        step(16'h0010, 1'b0, 1'b0);
        check_outputs("pre_async_reset", 1'b1, 4, FIXED ? 0 : 6);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs("async_reset", 1'b0, 0, 0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0:       rr = 16'h0000;
                1:       rr = 16'h0001 << $urandom_range(0, 15);
                2:       rr = 16'($urandom) & 16'($urandom);
                default: rr = 16'($urandom);
            endcase
            step(rr, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
            check_outputs($sformatf("rand%0d", c), m_valid, m_idx, m_ptr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
